// File: rtl/reg_spill_engine.sv
// rtl/reg_spill_engine.sv - register file save/restore sequencer to data memory
// Define CHECKSUM_EN to append (save) and verify (restore) an XOR checksum word after the flag word.
module reg_spill_engine #(
  parameter int pw = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          mode,
  input  logic [7:0]    baseAddr,
  output logic          busy,
  output logic          done,
  output logic [pw-1:0] rfReadAddr,
  input  logic [7:0]    rfData,
  input  logic          scryIn,
  input  logic          ngtvIn,
  input  logic          zeroIn,
  output logic          rfWriteEnable,
  output logic [pw-1:0] rfWriteAddr,
  output logic [7:0]    rfDataOut,
  output logic          scryOut,
  output logic          ngtvOut,
  output logic          zeroOut,
  output logic [7:0]    memAddr,
  output logic          memWriteEnable,
  output logic [7:0]    memDataOut,
`ifdef CHECKSUM_EN
  output logic          csumErr,
`endif
  input  logic [7:0]    memDataIn
);

  localparam int NREG = 2**pw;
  typedef logic [pw:0] cnt_t;
  localparam cnt_t CNT_LAST_REG = cnt_t'(NREG - 1);
  localparam cnt_t CNT_FLAG     = cnt_t'(NREG);
`ifdef CHECKSUM_EN
  localparam cnt_t CNT_CSUM      = cnt_t'(NREG + 1);
  localparam cnt_t CNT_SAVE_LAST = CNT_CSUM;
`else
  localparam cnt_t CNT_SAVE_LAST = CNT_FLAG;
`endif

  typedef enum logic [2:0] {
    IDLE,
    SAVE,
    RFLAG,
    RESTORE,
`ifdef CHECKSUM_EN
    RCSUM,
`endif
    DONE
  } state_t;

  state_t     state_q;
  cnt_t       cnt_q;
  logic [7:0] base_q;
  logic [2:0] flags_q;
`ifdef CHECKSUM_EN
  logic       mode_q;
  logic [7:0] csum_q;
  logic [7:0] ref_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      flags_q <= '0;
`ifdef CHECKSUM_EN
      mode_q  <= 1'b0;
      csum_q  <= '0;
      ref_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            base_q <= baseAddr;
            cnt_q  <= '0;
`ifdef CHECKSUM_EN
            mode_q  <= mode;
            csum_q  <= '0;
            state_q <= mode ? RCSUM : SAVE;
`else
            state_q <= mode ? RFLAG : SAVE;
`endif
          end
        end
        SAVE: begin
          cnt_q <= cnt_q + cnt_t'(1);
`ifdef CHECKSUM_EN
          csum_q <= csum_q ^ memDataOut;
`endif
          if (cnt_q == CNT_SAVE_LAST) state_q <= DONE;
        end
`ifdef CHECKSUM_EN
        RCSUM: begin
          ref_q   <= memDataIn;
          state_q <= RFLAG;
        end
`endif
        RFLAG: begin
          flags_q <= memDataIn[2:0];
          cnt_q   <= '0;
`ifdef CHECKSUM_EN
          csum_q  <= csum_q ^ memDataIn;
`endif
          state_q <= RESTORE;
        end
        RESTORE: begin
          cnt_q <= cnt_q + cnt_t'(1);
`ifdef CHECKSUM_EN
          csum_q <= csum_q ^ memDataIn;
`endif
          if (cnt_q == CNT_LAST_REG) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Every output is a pure decode of state; idle values are all zero.
  always_comb begin
    busy           = 1'b0;
    done           = 1'b0;
    rfReadAddr     = '0;
    rfWriteEnable  = 1'b0;
    rfWriteAddr    = '0;
    rfDataOut      = '0;
    scryOut        = 1'b0;
    ngtvOut        = 1'b0;
    zeroOut        = 1'b0;
    memAddr        = '0;
    memWriteEnable = 1'b0;
    memDataOut     = '0;
`ifdef CHECKSUM_EN
    csumErr        = 1'b0;
`endif
    case (state_q)
      SAVE: begin
        busy           = 1'b1;
        memWriteEnable = 1'b1;
        memAddr        = base_q + 8'(cnt_q);
        if (cnt_q < CNT_FLAG) begin
          rfReadAddr = cnt_q[pw-1:0];
          memDataOut = rfData;
        end else if (cnt_q == CNT_FLAG) begin
          memDataOut = {5'b0, scryIn, ngtvIn, zeroIn};
        end
`ifdef CHECKSUM_EN
        else begin
          memDataOut = csum_q;
        end
`endif
      end
`ifdef CHECKSUM_EN
      RCSUM: begin
        busy    = 1'b1;
        memAddr = base_q + 8'(CNT_CSUM);
      end
`endif
      RFLAG: begin
        busy    = 1'b1;
        memAddr = base_q + 8'(CNT_FLAG);
      end
      RESTORE: begin
        busy          = 1'b1;
        memAddr       = base_q + 8'(cnt_q);
        rfWriteEnable = 1'b1;
        rfWriteAddr   = cnt_q[pw-1:0];
        rfDataOut     = memDataIn;
        {scryOut, ngtvOut, zeroOut} = flags_q;
      end
      DONE: begin
        done = 1'b1;
`ifdef CHECKSUM_EN
        csumErr = mode_q && (csum_q != ref_q);
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_spill_engine.sv
// tb/tb_reg_spill_engine.sv - vector table plus write scoreboard for reg_spill_engine
// Bench models the register file and a 256-byte data memory around the DUT.
module tb_reg_spill_engine;

  localparam int PW   = 3;
  localparam int NREG = 8;
`ifdef CHECKSUM_EN
  localparam int NWORDS = NREG + 2;
`else
  localparam int NWORDS = NREG + 1;
`endif
  localparam int BUSY = NWORDS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, mode;
  logic [7:0]    baseAddr;
  logic          busy, done;
  logic [PW-1:0] rfReadAddr, rfWriteAddr;
  logic [7:0]    rfData, rfDataOut;
  logic          scryIn, ngtvIn, zeroIn;
  logic          rfWriteEnable;
  logic          scryOut, ngtvOut, zeroOut;
  logic [7:0]    memAddr, memDataOut, memDataIn;
  logic          memWriteEnable;
`ifdef CHECKSUM_EN
  logic          csumErr;
  logic          last_csum;
`endif

  reg_spill_engine #(.pw(PW)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .baseAddr(baseAddr),
    .busy(busy), .done(done), .rfReadAddr(rfReadAddr), .rfData(rfData),
    .scryIn(scryIn), .ngtvIn(ngtvIn), .zeroIn(zeroIn),
    .rfWriteEnable(rfWriteEnable), .rfWriteAddr(rfWriteAddr), .rfDataOut(rfDataOut),
    .scryOut(scryOut), .ngtvOut(ngtvOut), .zeroOut(zeroOut),
    .memAddr(memAddr), .memWriteEnable(memWriteEnable), .memDataOut(memDataOut),
`ifdef CHECKSUM_EN
    .csumErr(csumErr),
`endif
    .memDataIn(memDataIn)
  );

  logic [7:0] mem [256];
  logic [7:0] rf [NREG];
  logic [2:0] rf_flg;
  int         ld_kind;
  logic [7:0] ld_addr, ld_data;

  assign rfData    = rf[rfReadAddr];
  assign {scryIn, ngtvIn, zeroIn} = rf_flg;
  assign memDataIn = mem[memAddr];

  always @(posedge clk) begin
    if (memWriteEnable) mem[memAddr] <= memDataOut;
    else if (ld_kind == 1) mem[ld_addr] <= ld_data;
    if (rfWriteEnable) begin
      rf[rfWriteAddr] <= rfDataOut;
      rf_flg <= {scryOut, ngtvOut, zeroOut};
    end else if (ld_kind == 2) rf[ld_addr[PW-1:0]] <= ld_data;
    else if (ld_kind == 3) rf_flg <= ld_data[2:0];
  end

  int n_checks, n_fail;
  logic mon_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic [2:0] flg;
  } wr_t;
  wr_t mem_q[$];
  wr_t rf_q[$];

  always @(negedge clk) begin
    wr_t e;
    if (mon_en && memWriteEnable) begin
      if (mem_q.size() == 0) check("unexpected_mem_write", {memAddr, memDataOut}, 32'h1_0000);
      else begin
        e = mem_q.pop_front();
        check("mem_wr_addr", memAddr, e.addr);
        check("mem_wr_data", memDataOut, e.data);
      end
    end
    if (mon_en && rfWriteEnable) begin
      if (rf_q.size() == 0) check("unexpected_rf_write", {rfWriteAddr, rfDataOut}, 32'h1_0000);
      else begin
        e = rf_q.pop_front();
        check("rf_wr_addr", rfWriteAddr, e.addr[PW-1:0]);
        check("rf_wr_data", rfDataOut, e.data);
        check("rf_wr_flags", {scryOut, ngtvOut, zeroOut}, e.flg);
      end
    end
  end

  task automatic load(input int kind, input logic [7:0] a, input logic [7:0] d);
    ld_kind = kind; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_kind = 0;
  endtask

  task automatic push_save(input logic [7:0] b);
    wr_t e;
    logic [7:0] x;
    x = 8'h00;
    e.flg = 3'b000;
    for (int i = 0; i < NREG; i++) begin
      e.addr = b + 8'(i); e.data = rf[i]; x ^= rf[i];
      mem_q.push_back(e);
    end
    e.addr = b + 8'(NREG); e.data = {5'b0, rf_flg}; x ^= e.data;
    mem_q.push_back(e);
`ifdef CHECKSUM_EN
    e.addr = b + 8'(NREG + 1); e.data = x;
    mem_q.push_back(e);
`endif
  endtask

  task automatic push_restore(input logic [7:0] b);
    wr_t e;
    logic [7:0] fw;
    fw = mem[b + 8'(NREG)];
    e.flg = fw[2:0];
    for (int i = 0; i < NREG; i++) begin
      e.addr = 8'(i); e.data = mem[b + 8'(i)];
      rf_q.push_back(e);
    end
  endtask

  task automatic run_xfer(input logic m, input logic [7:0] b);
    logic [31:0] bv, dv;
    if (!m) push_save(b); else push_restore(b);
    mode = m; baseAddr = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mode = ~m; baseAddr = ~b;
    bv = '0; dv = '0;
    for (int k = 1; k <= BUSY + 2; k++) begin
      @(negedge clk);
      bv[k] = busy; dv[k] = done;
`ifdef CHECKSUM_EN
      if (done) last_csum = csumErr;
`endif
    end
    check("busy_window", bv, ((32'd1 << BUSY) - 32'd1) << 1);
    check("done_pulse", dv, 32'd1 << (BUSY + 1));
    check("sb_drained", mem_q.size() + rf_q.size(), 0);
    mode = 1'b0; baseAddr = 8'h00;
  endtask

  typedef struct {
    logic       mode;
    logic [7:0] base;
    logic [7:0] seed;
    logic [2:0] flg;
    logic [7:0] chk_addr;
    logic [7:0] chk_val;
  } vec_t;
  vec_t vecs[6];

  initial begin
    logic [31:0] bv, dv, eb;
    logic        ok;
    logic [7:0]  ev;
    n_checks = 0; n_fail = 0; mon_en = 1'b0;
    reset = 1'b1; start = 1'b0; mode = 1'b0; baseAddr = 8'h00;
    ld_kind = 0; ld_addr = 8'h00; ld_data = 8'h00;
    vecs[0] = '{mode: 1'b0, base: 8'h40, seed: 8'h00, flg: 3'b101, chk_addr: 8'h47, chk_val: 8'h88};
    vecs[1] = '{mode: 1'b1, base: 8'h40, seed: 8'h00, flg: 3'b101, chk_addr: 8'h00, chk_val: 8'h11};
    vecs[2] = '{mode: 1'b0, base: 8'hFC, seed: 8'h30, flg: 3'b010, chk_addr: 8'hFF, chk_val: 8'h33};
    vecs[3] = '{mode: 1'b1, base: 8'hFC, seed: 8'h30, flg: 3'b010, chk_addr: 8'h04, chk_val: 8'h34};
    vecs[4] = '{mode: 1'b0, base: 8'h00, seed: 8'hA0, flg: 3'b111, chk_addr: 8'h07, chk_val: 8'hA7};
    vecs[5] = '{mode: 1'b1, base: 8'h00, seed: 8'hA0, flg: 3'b111, chk_addr: 8'h00, chk_val: 8'hA0};

    repeat (3) @(negedge clk);
    check("rst_strobes", {busy, done, memWriteEnable, rfWriteEnable}, 0);
    check("rst_addr", {memAddr, rfReadAddr, rfWriteAddr}, 0);
    check("rst_data", {memDataOut, rfDataOut, scryOut, ngtvOut, zeroOut}, 0);
    reset = 1'b0; mon_en = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      if (!vecs[v].mode) begin
        for (int i = 0; i < NREG; i++)
          load(2, 8'(i), (vecs[v].seed == 8'h00) ? 8'(8'h11 * (i + 1)) : vecs[v].seed + 8'(i));
        load(3, 8'h00, {5'b0, vecs[v].flg});
      end else begin
        for (int i = 0; i < NREG; i++) load(2, 8'(i), 8'h00);
        load(3, 8'h00, 8'h00);
      end
      run_xfer(vecs[v].mode, vecs[v].base);
      if (!vecs[v].mode) begin
        check("vec_mem_word", mem[vecs[v].chk_addr], vecs[v].chk_val);
        check("vec_flag_word", mem[vecs[v].base + 8'(NREG)], {5'b0, vecs[v].flg});
      end else begin
        check("vec_reg", rf[vecs[v].chk_addr[PW-1:0]], vecs[v].chk_val);
        check("vec_rf_flags", rf_flg, vecs[v].flg);
        ok = 1'b1;
        for (int i = 0; i < NREG; i++) begin
          ev = (vecs[v].seed == 8'h00) ? 8'(8'h11 * (i + 1)) : vecs[v].seed + 8'(i);
          if (rf[i] !== ev) ok = 1'b0;
        end
        check("vec_all_regs", ok, 1);
      end
    end

    // Reset during busy cycle 4 of a save abandons the rest of the image.
    for (int i = 0; i < NWORDS; i++) load(1, 8'h80 + 8'(i), 8'hEE);
    for (int i = 0; i < NREG; i++) load(2, 8'(i), 8'h50 + 8'(i));
    load(3, 8'h00, 8'h06);
    push_save(8'h80);
    mode = 1'b0; baseAddr = 8'h80; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_busy_before_reset", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset_outputs", {busy, done, memWriteEnable, memAddr}, 0);
    check("mid_reset_words_written", mem_q.size(), NWORDS - 4);
    mem_q.delete();
    reset = 1'b0;
    ok = 1'b1;
    for (int i = 4; i < NWORDS; i++) if (mem[8'h80 + 8'(i)] !== 8'hEE) ok = 1'b0;
    check("mid_reset_mem_untouched", ok, 1);
    check("mid_reset_word3", mem[8'h83], 8'h53);
    @(negedge clk);
    run_xfer(1'b0, 8'h80);
    check("after_reset_flag_word", mem[8'h88], 8'h06);
    check("after_reset_word4", mem[8'h84], 8'h54);

    // start held high: one DONE and one IDLE cycle between transfers, inputs ignored while busy.
    for (int i = 0; i < NREG; i++) load(2, 8'(i), 8'h60 + 8'(i));
    load(3, 8'h00, 8'h03);
    push_save(8'h20);
    push_save(8'h20);
    mode = 1'b0; baseAddr = 8'h20; start = 1'b1;
    bv = '0; dv = '0;
    for (int k = 1; k <= 2 * BUSY + 4; k++) begin
      @(negedge clk);
      bv[k] = busy; dv[k] = done;
      if (k == 1 || k == BUSY + 3) begin mode = 1'b1; baseAddr = 8'h90; end
      if (k == BUSY + 1) begin mode = 1'b0; baseAddr = 8'h20; end
      if (k == BUSY + 2) check("held_idle_addr", {busy, memAddr}, 0);
      if (k == 2 * BUSY + 3) begin start = 1'b0; mode = 1'b0; baseAddr = 8'h00; end
    end
    eb = (((32'd1 << BUSY) - 32'd1) << 1) | (((32'd1 << BUSY) - 32'd1) << (BUSY + 3));
    check("held_busy_pattern", bv, eb);
    check("held_done_pattern", dv, (32'd1 << (BUSY + 1)) | (32'd1 << (2 * BUSY + 3)));
    check("held_sb_drained", mem_q.size(), 0);
    check("held_flag_word", mem[8'h28], 8'h03);

`ifdef CHECKSUM_EN
    for (int i = 0; i < NREG; i++) load(2, 8'(i), 8'h70 + 8'(i));
    load(3, 8'h00, 8'h05);
    run_xfer(1'b0, 8'h60);
    check("csum_save_done", last_csum, 0);
    for (int i = 0; i < NREG; i++) load(2, 8'(i), 8'h00);
    run_xfer(1'b1, 8'h60);
    check("csum_clean", last_csum, 0);
    load(1, 8'h63, mem[8'h63] ^ 8'h01);
    run_xfer(1'b1, 8'h60);
    check("csum_corrupt", last_csum, 1);
    check("csum_corrupt_reg_written", rf[3], 8'h72);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_spill_engine.md
Name: reg_spill_engine

Overview:
- Sequencer that saves the full register file plus its flags to data memory, or restores them from memory into the register file.
- Drives the register file's read address and write port on one side, and the data memory port on the other.
- Used for context save/restore (subroutine/interrupt entry and exit).
- Data memory has a combinational read and a clocked write.

Parameters:
pw, 3, register address width; the file has 2**pw registers of 8 bits.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE
mode  input  1  0 = save (regfile→mem), 1 = restore (mem→regfile); latched at start
baseAddr  input  8  memory base address; latched at start
busy  output  1  high while a transfer is in progress
done  output  1  one-cycle completion pulse
rfReadAddr  output  pw  register file read address
rfData  input  8  register file read data (combinational)
scryIn, ngtvIn, zeroIn  input  1 each  current register-file flags
rfWriteEnable  output  1  register file write strobe
rfWriteAddr  output  pw  register file write address
rfDataOut  output  8  register file write data
scryOut, ngtvOut, zeroOut  output  1 each  flag values presented with each register file write
memAddr  output  8  data memory address
memWriteEnable  output  1  data memory write strobe
memDataOut  output  8  data memory write data
memDataIn  input  8  data memory read data (combinational)

Behaviour:
- All outputs are Moore decodes of the registered state, counter and latched values.
- Memory image layout:
  - base+i = register i, for i = 0 .. 2**pw-1.
  - base+2**pw = flag word {5'b0, scry, ngtv, zero}.
  - Address arithmetic is 8-bit modulo 256; wrap past 0xFF is legal and silent.
- States: IDLE, SAVE, RFLAG, RESTORE, DONE.
- IDLE:
  - start=1 at posedge N: latch mode and baseAddr, clear counter cnt.
  - Next state is SAVE (mode=0) or RFLAG (mode=1).
  - start=0: stay in IDLE.
- SAVE, cnt = 0 .. 2**pw:
  - cnt < 2**pw: rfReadAddr=cnt, memAddr=base+cnt, memDataOut=rfData, memWriteEnable=1.
  - cnt = 2**pw: memAddr=base+2**pw, memDataOut={5'b0,scryIn,ngtvIn,zeroIn}, memWriteEnable=1.
  - cnt increments each cycle. After the flag word → DONE. Total 2**pw+1 busy cycles.
- RFLAG (1 cycle): memAddr=base+2**pw; capture memDataIn[2:0] into the flag holding register; → RESTORE with cnt=0.
- RESTORE, cnt = 0 .. 2**pw-1:
  - memAddr=base+cnt, rfWriteEnable=1, rfWriteAddr=cnt, rfDataOut=memDataIn.
  - scry/ngtv/zeroOut = held flags, so the register file ends holding the saved flags.
  - After cnt = 2**pw-1 → DONE. Total 2**pw+1 busy cycles.
- DONE (1 cycle): done=1, busy=0; → IDLE.
- Timing for start sampled at edge N: busy=1 in cycles N+1 .. N+2**pw+1; done=1 in cycle N+2**pw+2.
- busy=1 exactly in SAVE, RFLAG and RESTORE.
- start is ignored in every state except IDLE, including DONE. Back-to-back requests are therefore separated by at least the DONE cycle.
- When not in the driving state for that port:
  - memWriteEnable=0, rfWriteEnable=0.
  - Address and data outputs are 0; scry/ngtv/zeroOut are 0.
- Reset (synchronous, including mid-transfer):
  - State IDLE, cnt=0, latched mode/base/flags = 0.
  - busy=0, done=0, all strobes 0, all address/data outputs 0 from the next cycle.
  - A partially completed save or restore is abandoned, not completed.
- mode and baseAddr changes during busy have no effect.

Optional Feature:
Macro CHECKSUM_EN.
- Defined, save: one extra cycle after the flag word writes base+2**pw+1 = XOR of all 2**pw+1 previously written words. busy lasts 2**pw+2 cycles.
- Defined, restore:
  - Reads the checksum first (extra RFLAG-style cycle), then the flags, then the registers.
  - Keeps a running XOR; output port csumErr (1 bit) is valid in the DONE cycle, high on mismatch, 0 otherwise.
  - Register writes happen regardless of mismatch.
- Undefined: no checksum word, no csumErr port, timing exactly as above.

Test Plan:
- Save, base=0x40, regs r0..r7 = 0x11..0x88, flags scry=1 ngtv=0 zero=1 → mem[0x40..0x47]=0x11..0x88, mem[0x48]=0x05; busy 9 cycles; done one cycle at N+10.
- Restore, base=0x40, image from the previous test, regfile pre-cleared → r0..r7 = 0x11..0x88; register file flags = 1/0/1 after the last write; no memory writes occur.
- Wrap: save with base=0xFC → writes to 0xFC..0xFF then 0x00..0x04; flag word at 0x04.
- Reset asserted at busy cycle 4 of a save → next cycle busy=0, done=0, memWriteEnable=0; mem[base+4..base+8] unchanged; a following start runs a full, correct transfer.
- start held high continuously → transfers repeat with exactly one DONE and one IDLE cycle between them; start during busy never restarts or retargets the base.
- CHECKSUM_EN: save then restore with one memory byte corrupted between them (flip bit 0 of mem[base+3]) → csumErr=1 in the DONE cycle; with no corruption csumErr=0.
